// File: rtl/thresh_pwm_gen.sv
// thresh_pwm_gen: double-buffered VIL/VIH threshold PWM generator for the AFE.
// Each threshold is emitted as a fixed-period PWM whose high time is
// value << (CNT_W-8). New settings are held in pending registers and are
// only loaded into the active registers on a period boundary. A settled
// flag reports that a full period with the current pending values has gone out.
module thresh_pwm_gen #(
  parameter int CNT_W = 10
) (
  input  logic       smpl_clk,
  input  logic       rst,
  input  logic       wrt_VIL,
  input  logic [7:0] VIL_wdata,
  input  logic       wrt_VIH,
  input  logic [7:0] VIH_wdata,
  output logic       VIL_PWM,
  output logic       VIH_PWM,
  output logic [7:0] VIL_cur,
  output logic [7:0] VIH_cur,
  output logic       settled,
  output logic       err
);

  localparam int SH = CNT_W - 8;
  localparam logic [7:0] VIL_RST = 8'h55;
  localparam logic [7:0] VIH_RST = 8'hAA;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       vil_pend_q, vil_pend_d, vih_pend_q, vih_pend_d;
  logic [7:0]       vil_act_q, vil_act_d, vih_act_q, vih_act_d;
  logic             vil_pwm_q, vil_pwm_d, vih_pwm_q, vih_pwm_d;
  logic             dirty_q, dirty_d, armed_q, armed_d;
  logic             settled_q, settled_d, err_q, err_d;

  logic             boundary, wr_any, accept;
  logic [7:0]       vil_new, vih_new;
  logic [CNT_W-1:0] vil_thr, vih_thr;

  // Next-state: counter, PWM compare, write acceptance, boundary load, settle tracking
  always_comb begin
    boundary = &cnt_q;
    vil_new  = wrt_VIL ? VIL_wdata : vil_pend_q;
    vih_new  = wrt_VIH ? VIH_wdata : vih_pend_q;
    wr_any   = wrt_VIL | wrt_VIH;
    // Only an ordered pair (VIL strictly below VIH) may reach the pending regs.
    accept   = wr_any && (vil_new < vih_new);
    vil_thr  = CNT_W'(vil_act_q) << SH;
    vih_thr  = CNT_W'(vih_act_q) << SH;

    cnt_d      = cnt_q + CNT_W'(1);
    vil_pwm_d  = cnt_q < vil_thr;
    vih_pwm_d  = cnt_q < vih_thr;
    err_d      = wr_any && !accept;
    vil_pend_d = vil_pend_q;
    vih_pend_d = vih_pend_q;
    vil_act_d  = vil_act_q;
    vih_act_d  = vih_act_q;
    dirty_d    = dirty_q;
    armed_d    = armed_q;
    settled_d  = settled_q;

    // The load always takes the pend value from before this edge, so a
    // write landing on the boundary cycle only takes effect a period later.
    if (boundary) begin
      vil_act_d = vil_pend_q;
      vih_act_d = vih_pend_q;
    end

    if (accept) begin
      vil_pend_d = vil_new;
      vih_pend_d = vih_new;
      dirty_d    = 1'b1;
      armed_d    = 1'b0;
      settled_d  = 1'b0;
    end else if (boundary) begin
      if (dirty_q) begin
        dirty_d = 1'b0;
        armed_d = 1'b1;
      end else if (armed_q) begin
        settled_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset to the default thresholds
  always_ff @(posedge smpl_clk) begin
    if (rst) begin
      cnt_q      <= '0;
      vil_pend_q <= VIL_RST;
      vih_pend_q <= VIH_RST;
      vil_act_q  <= VIL_RST;
      vih_act_q  <= VIH_RST;
      vil_pwm_q  <= 1'b0;
      vih_pwm_q  <= 1'b0;
      dirty_q    <= 1'b0;
      armed_q    <= 1'b1;
      settled_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      vil_pend_q <= vil_pend_d;
      vih_pend_q <= vih_pend_d;
      vil_act_q  <= vil_act_d;
      vih_act_q  <= vih_act_d;
      vil_pwm_q  <= vil_pwm_d;
      vih_pwm_q  <= vih_pwm_d;
      dirty_q    <= dirty_d;
      armed_q    <= armed_d;
      settled_q  <= settled_d;
      err_q      <= err_d;
    end
  end

  assign VIL_PWM = vil_pwm_q;
  assign VIH_PWM = vih_pwm_q;
  assign VIL_cur = vil_act_q;
  assign VIH_cur = vih_act_q;
  assign settled = settled_q;
  assign err     = err_q;

endmodule

// File: tb/tb_thresh_pwm_gen.sv
// Bench for thresh_pwm_gen: directed period-level scenarios plus a randomized
// cycle-by-cycle comparison against a behavioural model.
module tb_thresh_pwm_gen;

  localparam int PER = 1024;

  logic       smpl_clk = 1'b0;
  logic       rst = 1'b1;
  logic       wrt_VIL = 1'b0, wrt_VIH = 1'b0;
  logic [7:0] VIL_wdata = 8'h00, VIH_wdata = 8'h00;
  logic       VIL_PWM, VIH_PWM, settled, err;
  logic [7:0] VIL_cur, VIH_cur;

  int errors = 0;
  int checks = 0;

  // Behavioural model: pending/active values, period phase, and settle
  // tracked as "boundaries seen since the last accepted write".
  int m_cnt, m_pl, m_ph, m_al, m_ah, m_bnd, m_need;
  bit m_pwml, m_pwmh, m_set, m_err;

  thresh_pwm_gen #(.CNT_W(10)) dut (
    .smpl_clk (smpl_clk),
    .rst      (rst),
    .wrt_VIL  (wrt_VIL),
    .VIL_wdata(VIL_wdata),
    .wrt_VIH  (wrt_VIH),
    .VIH_wdata(VIH_wdata),
    .VIL_PWM  (VIL_PWM),
    .VIH_PWM  (VIH_PWM),
    .VIL_cur  (VIL_cur),
    .VIH_cur  (VIH_cur),
    .settled  (settled),
    .err      (err)
  );

  always #5 smpl_clk = ~smpl_clk;

  // Drive one cycle of inputs, advance the model, then wait past the edge.
  task automatic step(input bit r, input bit wl, input int dl, input bit wh, input int dh);
    bit bnd, any, acc;
    int nl, nh;
    rst = r; wrt_VIL = wl; VIL_wdata = 8'(dl); wrt_VIH = wh; VIH_wdata = 8'(dh);
    if (r) begin
      m_cnt = 0; m_pl = 'h55; m_ph = 'hAA; m_al = 'h55; m_ah = 'hAA;
      m_pwml = 0; m_pwmh = 0; m_set = 0; m_err = 0; m_bnd = 0; m_need = 1;
    end else begin
      bnd = (m_cnt == PER - 1);
      any = wl | wh;
      nl = wl ? dl : m_pl;
      nh = wh ? dh : m_ph;
      acc = any && (nl < nh);
      m_err = any && !acc;
      m_pwml = m_cnt < 4 * m_al;
      m_pwmh = m_cnt < 4 * m_ah;
      if (bnd) begin m_al = m_pl; m_ah = m_ph; end
      if (acc) begin
        m_pl = nl; m_ph = nh; m_bnd = 0; m_need = 2; m_set = 0;
      end else if (bnd) begin
        m_bnd++;
        if (m_bnd >= m_need) m_set = 1;
      end
      m_cnt = (m_cnt + 1) % PER;
    end
    @(posedge smpl_clk); #1;
    wrt_VIL = 1'b0; wrt_VIH = 1'b0;
  endtask

  // Idle for n cycles, counting high cycles on each PWM line.
  task automatic run_cycles(input int n, output int hl, output int hh);
    hl = 0; hh = 0;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 0);
      hl += int'(VIL_PWM);
      hh += int'(VIH_PWM);
    end
  endtask

  task automatic test_reset();
    int hl, hh, first_low;
    bit early_set;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    checks++; if (VIL_PWM !== 1'b0 || VIH_PWM !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b%b want 00", VIL_PWM, VIH_PWM); end
    checks++; if (VIL_cur !== 8'h55 || VIH_cur !== 8'hAA) begin errors++; $display("FAIL reset_cur: got %h/%h want 55/aa", VIL_cur, VIH_cur); end
    checks++; if (settled !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: got settled=%b err=%b want 0 0", settled, err); end
    hl = 0; hh = 0; first_low = 0; early_set = 0;
    for (int e = 1; e <= PER; e++) begin
      step(0, 0, 0, 0, 0);
      hl += int'(VIL_PWM); hh += int'(VIH_PWM);
      if (VIL_PWM === 1'b0 && first_low == 0) first_low = e;
      if (e < PER && settled === 1'b1) early_set = 1;
    end
    checks++; if (hl != 340 || hh != 680) begin errors++; $display("FAIL reset_period_high: got %0d/%0d want 340/680", hl, hh); end
    checks++; if (first_low != 341) begin errors++; $display("FAIL reset_first_low_edge: got %0d want 341", first_low); end
    checks++; if (early_set || settled !== 1'b1) begin errors++; $display("FAIL reset_settle_time: got early=%b settled=%b want 0 1", early_set, settled); end
  endtask

  task automatic test_write_mid();
    int hl, hh;
    run_cycles(500, hl, hh);
    checks++; if (hl != 340) begin errors++; $display("FAIL wmid_pre_high: got %0d want 340", hl); end
    step(0, 1, 'h40, 0, 0);
    checks++; if (settled !== 1'b0 || err !== 1'b0 || VIL_cur !== 8'h55) begin errors++; $display("FAIL wmid_after_write: got settled=%b err=%b cur=%h want 0 0 55", settled, err, VIL_cur); end
    run_cycles(PER - m_cnt, hl, hh);
    checks++; if (VIL_cur !== 8'h40 || settled !== 1'b0) begin errors++; $display("FAIL wmid_load: got cur=%h settled=%b want 40 0", VIL_cur, settled); end
    run_cycles(PER - 1, hl, hh);
    checks++; if (hl != 256 || hh != 680 || settled !== 1'b0) begin errors++; $display("FAIL wmid_new_period: got %0d/%0d settled=%b want 256/680 0", hl, hh, settled); end
    step(0, 0, 0, 0, 0);
    checks++; if (settled !== 1'b1) begin errors++; $display("FAIL wmid_settle: got %b want 1", settled); end
  endtask

  task automatic test_err();
    int hl, hh;
    run_cycles(10, hl, hh);
    step(0, 1, 'hB0, 0, 0);
    checks++; if (err !== 1'b1 || settled !== 1'b1 || VIL_cur !== 8'h40) begin errors++; $display("FAIL err_above: got err=%b settled=%b cur=%h want 1 1 40", err, settled, VIL_cur); end
    step(0, 0, 0, 0, 0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b want 0", err); end
    step(0, 0, 0, 1, 'h40);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_equal: got %b want 1", err); end
    run_cycles(PER - m_cnt, hl, hh);
    run_cycles(PER, hl, hh);
    checks++; if (hl != 256 || hh != 680 || settled !== 1'b1) begin errors++; $display("FAIL err_no_effect: got %0d/%0d settled=%b want 256/680 1", hl, hh, settled); end
  endtask

  task automatic test_dual();
    int hl, hh;
    run_cycles(100, hl, hh);
    step(0, 1, 'hC0, 1, 'hE0);
    checks++; if (err !== 1'b0 || settled !== 1'b0) begin errors++; $display("FAIL dual_accept: got err=%b settled=%b want 0 0", err, settled); end
    run_cycles(PER - m_cnt, hl, hh);
    checks++; if (VIL_cur !== 8'hC0 || VIH_cur !== 8'hE0) begin errors++; $display("FAIL dual_cur: got %h/%h want c0/e0", VIL_cur, VIH_cur); end
    run_cycles(PER, hl, hh);
    checks++; if (hl != 768 || hh != 896 || settled !== 1'b1) begin errors++; $display("FAIL dual_period: got %0d/%0d settled=%b want 768/896 1", hl, hh, settled); end
  endtask

  task automatic test_extremes();
    int hl, hh;
    step(0, 1, 'h00, 1, 'hFF);
    run_cycles(PER - m_cnt, hl, hh);
    for (int p = 0; p < 2; p++) begin
      run_cycles(PER, hl, hh);
      checks++; if (hl != 0 || hh != 1020) begin errors++; $display("FAIL extreme_period%0d: got %0d/%0d want 0/1020", p, hl, hh); end
    end
    checks++; if (settled !== 1'b1) begin errors++; $display("FAIL extreme_settle: got %b want 1", settled); end
  endtask

  task automatic test_back_to_back();
    int hl, hh;
    run_cycles(PER - 1 - m_cnt, hl, hh);
    step(0, 1, 'h10, 1, 'h20);   // lands on the boundary cycle
    checks++; if (VIL_cur !== 8'h00 || VIH_cur !== 8'hFF || settled !== 1'b0) begin errors++; $display("FAIL bnd_old_load: got %h/%h settled=%b want 00/ff 0", VIL_cur, VIH_cur, settled); end
    run_cycles(PER, hl, hh);
    checks++; if (hl != 0 || hh != 1020 || VIL_cur !== 8'h10 || VIH_cur !== 8'h20 || settled !== 1'b0) begin errors++; $display("FAIL bnd_deferred: got %0d/%0d cur=%h/%h settled=%b want 0/1020 10/20 0", hl, hh, VIL_cur, VIH_cur, settled); end
    run_cycles(PER, hl, hh);
    checks++; if (hl != 64 || hh != 128 || settled !== 1'b1) begin errors++; $display("FAIL bnd_new_period: got %0d/%0d settled=%b want 64/128 1", hl, hh, settled); end
    // Mid-period reset discards a pending write.
    run_cycles(20, hl, hh);
    step(0, 1, 'h18, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++; if (VIL_PWM !== 1'b1 || VIH_PWM !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b%b want 11", VIL_PWM, VIH_PWM); end
    step(1, 0, 0, 0, 0);
    checks++; if (VIL_PWM !== 1'b0 || VIH_PWM !== 1'b0 || VIL_cur !== 8'h55 || VIH_cur !== 8'hAA || settled !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_state: got pwm=%b%b cur=%h/%h s=%b e=%b want 00 55/aa 0 0", VIL_PWM, VIH_PWM, VIL_cur, VIH_cur, settled, err); end
    run_cycles(PER, hl, hh);
    checks++; if (hl != 340 || hh != 680 || settled !== 1'b1) begin errors++; $display("FAIL midrst_period: got %0d/%0d settled=%b want 340/680 1", hl, hh, settled); end
  endtask

  task automatic test_random();
    bit r, wl, wh;
    int dl, dh;
    for (int i = 0; i < 12000; i++) begin
      r  = ($urandom_range(0, 3999) == 0);
      wl = ((i % 3000) < 1500) && ($urandom_range(0, 59) == 0);
      wh = ((i % 3000) < 1500) && ($urandom_range(0, 59) == 0);
      dl = $urandom_range(0, 255);
      dh = $urandom_range(0, 255);
      step(r, wl, dl, wh, dh);
      checks++; if (VIL_PWM !== m_pwml || VIH_PWM !== m_pwmh) begin errors++; $display("FAIL rnd_pwm @%0d: got %b%b want %b%b", i, VIL_PWM, VIH_PWM, m_pwml, m_pwmh); end
      checks++; if (VIL_cur !== 8'(m_al) || VIH_cur !== 8'(m_ah)) begin errors++; $display("FAIL rnd_cur @%0d: got %h/%h want %h/%h", i, VIL_cur, VIH_cur, m_al, m_ah); end
      checks++; if (settled !== m_set || err !== m_err) begin errors++; $display("FAIL rnd_flags @%0d: got s=%b e=%b want %b %b", i, settled, err, m_set, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_write_mid();
    test_err();
    test_dual();
    test_extremes();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
